apb_cmd_master: RTL and testbench

- APB initiator: turns a command stream (write/read, address, data) into single APB3 transfers and returns one response per command.
- Drives the register block's APB slave port from a non-CPU source, e.g. a USB command decoder or a boot-time config sequencer.
- One transfer outstanding at a time; wait states (pready), slave error (pslverr) and a timeout guard are handled.

---
 rtl/apb_cmd_master.sv | 147 ++++++++++++++
 tb/tb_apb_cmd_master.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB3 initiator: converts a command stream into single APB transfers with one response per command.
// Handles wait states, slave errors and an optional ACCESS-phase timeout.
module apb_cmd_master #(
  parameter int unsigned ADDR_W  = 40,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

  state_t            state, state_n;
  logic [TO_W-1:0]   cnt, cnt_n;
  logic [ADDR_W-1:0] paddr_n;
  logic              pwrite_n, psel_n, penable_n;
  logic [31:0]       pwdata_n, rsp_rdata_n;
  logic              rsp_valid_n, rsp_err_n, rsp_timeout_n, busy_n;

  // Byte-lane bits of the command address never reach the bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cmd_addr[1:0];

  assign cmd_ready = (state == S_IDLE) && reset_n;

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    paddr_n       = paddr;
    pwrite_n      = pwrite;
    pwdata_n      = pwdata;
    psel_n        = psel;
    penable_n     = penable;
    rsp_valid_n   = rsp_valid;
    rsp_rdata_n   = rsp_rdata;
    rsp_err_n     = rsp_err;
    rsp_timeout_n = rsp_timeout;

    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          paddr_n   = {cmd_addr[ADDR_W-1:2], 2'b00};
          pwrite_n  = cmd_write;
          pwdata_n  = cmd_write ? cmd_wdata : '0;
          psel_n    = 1'b1;
          penable_n = 1'b0;
          state_n   = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_n = 1'b1;
        cnt_n     = '0;
        state_n   = S_ACCESS;
      end
      S_ACCESS: begin
        // Completion is checked first so a pready on the limit cycle wins over the abort.
        if (pready) begin
          psel_n        = 1'b0;
          penable_n     = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_err_n     = pslverr;
          rsp_timeout_n = 1'b0;
          rsp_rdata_n   = pwrite ? '0 : prdata;
          state_n       = S_RESP;
        end else if (TO_EN && (cnt == TO_LAST)) begin
          psel_n        = 1'b0;
          penable_n     = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_err_n     = 1'b1;
          rsp_timeout_n = 1'b1;
          rsp_rdata_n   = '0;
          state_n       = S_RESP;
        end else if (cnt != '1) begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      paddr       <= paddr_n;
      pwrite      <= pwrite_n;
      pwdata      <= pwdata_n;
      psel        <= psel_n;
      penable     <= penable_n;
      rsp_valid   <= rsp_valid_n;
      rsp_rdata   <= rsp_rdata_n;
      rsp_err     <= rsp_err_n;
      rsp_timeout <= rsp_timeout_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: transaction-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_apb_cmd_master;

  localparam int unsigned AW = 40;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0]   rsp_rdata;
  logic          psel, penable, pwrite, pready, pslverr, busy;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata, prdata;

  always #5 clk = ~clk;

  apb_cmd_master #(.ADDR_W(AW), .TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one command in flight, tracked by edges since acceptance and
  // the number of low-pready access cycles seen so far.
  bit            m_busy = 1'b0;
  bit            m_resp = 1'b0;
  int            m_cyc  = 0;
  int            m_wait = 0;
  bit            m_w    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [31:0]   m_wdata = '0;
  logic [31:0]   m_rdata = '0;
  bit            m_err = 1'b0;
  bit            m_to  = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0;
      m_resp = 1'b0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy  = 1'b1;
        m_cyc   = 0;
        m_wait  = 0;
        m_w     = cmd_write;
        m_addr  = cmd_addr - (cmd_addr % 4);
        m_wdata = cmd_write ? cmd_wdata : 32'h0;
      end
    end else if (m_resp) begin
      if (rsp_ready) begin
        m_busy = 1'b0;
        m_resp = 1'b0;
      end
    end else begin
      m_cyc++;
      if (m_cyc >= 2) begin
        if (pready) begin
          m_resp  = 1'b1;
          m_err   = pslverr;
          m_to    = 1'b0;
          m_rdata = m_w ? 32'h0 : prdata;
        end else if (TO != 0 && m_wait + 1 == int'(TO)) begin
          m_resp  = 1'b1;
          m_err   = 1'b1;
          m_to    = 1'b1;
          m_rdata = 32'h0;
        end else begin
          m_wait++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("cmd_ready", 64'(cmd_ready), 64'(!m_busy));
      chk("busy",      64'(busy),      64'(m_busy));
      chk("psel",      64'(psel),      64'(m_busy && !m_resp));
      chk("penable",   64'(penable),   64'(m_busy && !m_resp && m_cyc >= 1));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_resp));
      if (m_busy && !m_resp) begin
        chk("paddr",  64'(paddr),  64'(m_addr));
        chk("pwrite", 64'(pwrite), 64'(m_w));
        chk("pwdata", 64'(pwdata), 64'(m_wdata));
      end
      if (m_resp) begin
        chk("rsp_rdata",   64'(rsp_rdata),   64'(m_rdata));
        chk("rsp_err",     64'(rsp_err),     64'(m_err));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(m_to));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called from IDLE; returns 1 ns after the acceptance edge (SETUP cycle).
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    chk("send_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    pready    = 1'b1;
    pslverr   = 1'b0;
    prdata    = 32'hBAD0_BAD0;

    repeat (3) tick();
    chk("rst_psel",      64'(psel),      64'd0);
    chk("rst_penable",   64'(penable),   64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_paddr",     64'(paddr),     64'd0);
    chk("rst_pwdata",    64'(pwdata),    64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    reset_n = 1'b1;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();

    // Zero-wait write
    send(1'b1, 40'h000, 32'h3);
    chk("w0_psel",    64'(psel),    64'd1);
    chk("w0_penable", 64'(penable), 64'd0);
    chk("w0_paddr",   64'(paddr),   64'h0);
    chk("w0_pwdata",  64'(pwdata),  64'h3);
    chk("w0_pwrite",  64'(pwrite),  64'd1);
    tick();
    chk("w0_penable2", 64'(penable), 64'd1);
    tick();
    chk("w0_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("w0_rsp_err",   64'(rsp_err),   64'd0);
    chk("w0_rsp_rdata", 64'(rsp_rdata), 64'd0);
    tick();
    chk("w0_rsp_done", 64'(rsp_valid), 64'd0);

    // Read with three wait states, unaligned address
    pready = 1'b0;
    prdata = 32'h1234_5678;
    send(1'b0, 40'h03B, 32'hDEAD_BEEF);
    chk("rd_paddr",  64'(paddr),  64'h38);
    chk("rd_pwdata", 64'(pwdata), 64'h0);
    chk("rd_pwrite", 64'(pwrite), 64'd0);
    tick();
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (penable) n++;
      chk("rd_paddr_stable", 64'(paddr), 64'h38);
      tick();
    end
    if (penable) n++;
    pready = 1'b1;
    prdata = 32'h5;
    tick();
    chk("rd_penable_cycles", 64'(n), 64'd4);
    chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rd_rsp_rdata", 64'(rsp_rdata), 64'h5);
    chk("rd_rsp_err",   64'(rsp_err),   64'd0);
    prdata = 32'hBAD0_BAD0;
    tick();

    // Slave error, then a normal command
    pslverr = 1'b1;
    send(1'b1, 40'h100, 32'hCAFE);
    tick();
    tick();
    chk("se_rsp_err", 64'(rsp_err),     64'd1);
    chk("se_rsp_to",  64'(rsp_timeout), 64'd0);
    pslverr = 1'b0;
    tick();
    send(1'b1, 40'h104, 32'h1);
    tick();
    tick();
    chk("se_next_valid", 64'(rsp_valid), 64'd1);
    chk("se_next_err",   64'(rsp_err),   64'd0);
    tick();

    // Timeout: pready held low
    pready = 1'b0;
    prdata = 32'hFFFF_FFFF;
    send(1'b0, 40'h44, 32'h0);
    n = 0;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      tick();
      if (penable) n++;
    end
    chk("to_access_cycles", 64'(n), 64'd4);
    chk("to_rsp_valid", 64'(rsp_valid),   64'd1);
    chk("to_rsp_err",   64'(rsp_err),     64'd1);
    chk("to_rsp_to",    64'(rsp_timeout), 64'd1);
    chk("to_rsp_rdata", 64'(rsp_rdata),   64'd0);
    chk("to_psel",      64'(psel),        64'd0);
    tick();

    // pready rises on the limit cycle: completion wins
    send(1'b0, 40'h48, 32'h0);
    tick();
    tick();
    tick();
    tick();
    pready = 1'b1;
    prdata = 32'h77;
    tick();
    chk("tl_rsp_valid", 64'(rsp_valid),   64'd1);
    chk("tl_rsp_to",    64'(rsp_timeout), 64'd0);
    chk("tl_rsp_err",   64'(rsp_err),     64'd0);
    chk("tl_rsp_rdata", 64'(rsp_rdata),   64'h77);
    prdata = 32'hBAD0_BAD0;
    tick();

    // Response backpressure with a second command waiting
    rsp_ready = 1'b0;
    send(1'b1, 40'h200, 32'h11);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 40'h204;
    cmd_wdata = 32'h0;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("bp_psel",      64'(psel),      64'd0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_rdata", 64'(rsp_rdata), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_hs_valid", 64'(rsp_valid), 64'd0);
    chk("bp_hs_ready", 64'(cmd_ready), 64'd1);
    chk("bp_hs_psel",  64'(psel),      64'd0);
    tick();
    chk("bp_next_psel",  64'(psel),  64'd1);
    chk("bp_next_paddr", 64'(paddr), 64'h204);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (psel && !penable) break;
    end
    chk("b2b_interval", 64'(n), 64'd4);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("b2b_drain", 64'(busy), 64'd0);

    // Reset during ACCESS
    pready = 1'b0;
    send(1'b0, 40'h300, 32'h0);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("ra_psel",      64'(psel),      64'd0);
    chk("ra_penable",   64'(penable),   64'd0);
    chk("ra_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("ra_busy",      64'(busy),      64'd0);
    tick();
    reset_n = 1'b1;
    pready  = 1'b1;
    #1;
    chk("ra_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    send(1'b1, 40'h8, 32'h9);
    tick();
    tick();
    chk("ra_next_valid", 64'(rsp_valid), 64'd1);
    chk("ra_next_err",   64'(rsp_err),   64'd0);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
